// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default parameter values for the UART TX arbiter.
// Optional watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    s_ARB_IDLE    = 2'd0,
    s_ARB_ISSUE   = 2'd1,
    s_ARB_WAIT    = 2'd2,
    s_ARB_CLEANUP = 2'd3
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_TIMEOUT_DEF = 100000;

endpackage

// File: rtl/uart_tx_rr_picker.sv
// Combinational round-robin picker: first active request at or above the
// pointer, wrapping past NUM_REQ-1 back to 0.
module uart_tx_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [PTR_W-1:0]   i_Ptr,
  output logic [NUM_REQ-1:0] o_Onehot,
  output logic [PTR_W-1:0]   o_Idx,
  output logic               o_Any
);

  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    o_Onehot = '0;
    o_Idx    = '0;
    o_Any    = |i_Req;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, i_Ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && i_Req[idx]) begin
        found         = 1'b1;
        o_Idx         = idx;
        o_Onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to add a watchdog on the core's done pulse.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [NUM_REQ*8-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  uart_tx_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_Req    (i_Req_DV),
    .i_Ptr    (rr_ptr_q),
    .o_Onehot (pick_onehot),
    .o_Idx    (pick_idx),
    .o_Any    (pick_any)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= s_ARB_IDLE;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    logic finish;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    timeout_d = 1'b0;
    finish    = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      s_ARB_IDLE: begin
        // Ack and start pulse are registered here so they appear during ISSUE.
        if (pick_any && !i_Tx_Active) begin
          state_d   = s_ARB_ISSUE;
          grant_d   = pick_onehot;
          ack_d     = pick_onehot;
          tx_dv_d   = 1'b1;
          tx_byte_d = i_Req_Byte[{pick_idx, 3'b000} +: 8];
          win_idx_d = pick_idx;
        end
      end
      s_ARB_ISSUE: begin
        state_d = s_ARB_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      s_ARB_WAIT: begin
        if (i_Tx_Done) begin
          finish = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          finish    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = s_ARB_IDLE;
    endcase
    if (finish) begin
      state_d  = s_ARB_CLEANUP;
      grant_d  = '0;
      rr_ptr_d = (win_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
    end
    busy_d = (state_d != s_ARB_IDLE);
  end

  assign o_Req_Ack = ack_q;
  assign o_Grant   = grant_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Busy    = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign o_Timeout = timeout_q;
`else
  assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (4 requesters, 20-cycle watchdog
// when UART_TX_ARB_TIMEOUT_EN is defined).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_dv = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(20)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_DV    (req_dv),
    .i_Req_Byte  (req_byte),
    .o_Req_Ack   (req_ack),
    .o_Grant     (grant),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Busy      (busy),
    .o_Timeout   (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_dv    = '0;
    tx_done   = 1'b0;
    tx_active = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Done pulse from WAIT; leaves the bench in the first IDLE cycle.
  task automatic finish_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_ack, grant, tx_dv, tx_byte, busy, timeout} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b grant=%b dv=%b byte=%h busy=%b to=%b exp all 0",
               req_ack, grant, tx_dv, tx_byte, busy, timeout);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req_byte = 32'h00A5_0000;
    req_dv   = 4'b0100;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || tx_dv !== 1'b1 || req_ack !== 4'b0100 || tx_byte !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_issue got grant=%b dv=%b ack=%b byte=%h exp 0100 1 0100 a5",
               grant, tx_dv, req_ack, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b0100 || tx_dv !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait got grant=%b dv=%b ack=%b busy=%b exp 0100 0 0000 1",
               grant, tx_dv, req_ack, busy);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cleanup got grant=%b busy=%b exp 0000 1", grant, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle got busy=%b exp 0", busy);
    end
    // rr_ptr should now be 3, so requester 3 beats requester 0.
    req_byte = 32'h3300_0000 | 32'h0000_0000;
    req_dv   = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || tx_byte !== 8'h33) begin
      n_fail++;
      $display("FAIL single_rrptr got grant=%b byte=%h exp 1000 33", grant, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    finish_tx();
    $display("[TB] test_single done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [5];
    int n;
    exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h12;
    exp_seq[3] = 8'h13; exp_seq[4] = 8'h10;
    do_reset();
    req_byte = 32'h1312_1110;
    req_dv   = 4'b1111;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      while (tx_dv !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      n_checks++;
      if (tx_dv !== 1'b1 || tx_byte !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got dv=%b byte=%h exp 1 %h", i, tx_dv, tx_byte, exp_seq[i]);
      end
      n_checks++;
      if (n !== ((i == 0) ? 1 : 3)) begin
        n_fail++;
        $display("FAIL b2b_latency%0d got %0d cycles exp %0d", i, n, (i == 0) ? 1 : 3);
      end
      $display("[TB] b2b txn %0d byte=%h latency=%0d", i, tx_byte, n);
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n = 1;
    end
    req_dv = 4'b0000;
    tick();
    tick();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_tx_active();
    do_reset();
    tx_active = 1'b1;
    req_byte  = 32'h0000_0077;
    req_dv    = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (grant !== 4'b0000 || tx_dv !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL active_hold got grant=%b dv=%b busy=%b exp 0000 0 0", grant, tx_dv, busy);
    end
    tx_active = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || tx_dv !== 1'b1 || tx_byte !== 8'h77) begin
      n_fail++;
      $display("FAIL active_release got grant=%b dv=%b byte=%h exp 0001 1 77", grant, tx_dv, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    finish_tx();
    $display("[TB] test_tx_active done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_dv = 4'b0001;
    tick();
    req_dv = 4'b0000;
    tick();
    finish_tx();
    req_byte = 32'h005A_0000;
    req_dv   = 4'b0100;
    tick();
    req_dv = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ack, grant, tx_dv, tx_byte, busy, timeout} !== 19'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got ack=%b grant=%b dv=%b byte=%h busy=%b exp all 0",
               req_ack, grant, tx_dv, tx_byte, busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (req_ack !== 4'b0000 || tx_dv !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_noack got ack=%b dv=%b exp 0000 0", req_ack, tx_dv);
      end
    end
    // rr_ptr back at 0: requester 0 wins over requester 1.
    req_byte = 32'h0000_2211;
    req_dv   = 4'b0011;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || tx_byte !== 8'h11) begin
      n_fail++;
      $display("FAIL midreset_rrptr got grant=%b byte=%h exp 0001 11", grant, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    finish_tx();
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_stray_done();
    do_reset();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || tx_dv !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done got busy=%b grant=%b dv=%b to=%b exp 0 0000 0 0",
               busy, grant, tx_dv, timeout);
    end
    req_byte = 32'h0000_3C00;
    req_dv   = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || req_ack !== 4'b0010 || tx_dv !== 1'b1 || tx_byte !== 8'h3C) begin
      n_fail++;
      $display("FAIL stray_serve got grant=%b ack=%b dv=%b byte=%h exp 0010 0010 1 3c",
               grant, req_ack, tx_dv, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    finish_tx();
    $display("[TB] test_stray_done done");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_byte = 32'h0000_BBAA;
    req_dv   = 4'b0011;
    tick();
    tick();
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (timeout !== 1'b1 || n !== 20 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_pulse got to=%b after %0d cycles grant=%b exp 1 after 20 grant 0000",
               timeout, n, grant);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width got to=%b exp 0", timeout);
    end
    tick();
    n_checks++;
    if (grant !== 4'b0010 || tx_byte !== 8'hBB) begin
      n_fail++;
      $display("FAIL timeout_next got grant=%b byte=%h exp 0010 bb", grant, tx_byte);
    end
    req_dv = 4'b0000;
    tick();
    finish_tx();
    $display("[TB] test_timeout done");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got simulation still running exp finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_active();
    test_reset_mid();
    test_stray_done();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter core between `NUM_REQ` byte producers, for example a command responder, a status reporter and a debug streamer. Sits between the requesters and the UART TX core's `i_Tx_DV`/`i_Tx_Byte` inputs. Round-robin arbitration gives each requester fair access. The block issues exactly one byte per grant and waits for the core's done pulse before arbitrating again.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 100000: watchdog limit in clocks. Used only when `UART_TX_ARB_TIMEOUT_EN` is defined.
- `i_Clock`  in  1  system clock.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req_DV`  in  NUM_REQ  per-requester "byte valid". The requester holds it, together with its byte, until acknowledged.
- `i_Req_Byte`  in  NUM_REQ*8  packed bytes. Requester n uses bits [8n+7:8n].
- `o_Req_Ack`  out  NUM_REQ  one-hot, one-cycle pulse. Marks the byte as accepted.
- `o_Grant`  out  NUM_REQ  one-hot. Shows the current owner of the transmitter; zero when idle.
- `o_Tx_DV`  out  1  one-cycle start pulse to the UART TX core.
- `o_Tx_Byte`  out  8  registered byte to the UART TX core.
- `i_Tx_Active`  in  1  UART TX core busy flag.
- `i_Tx_Done`  in  1  UART TX core one-cycle done pulse.
- `o_Busy`  out  1  high in every state except `s_ARB_IDLE`.
- `o_Timeout`  out  1  one-cycle pulse when the watchdog aborts a transfer. Constant 0 without the macro.

## Operation
- States:
  - `s_ARB_IDLE`
  - `s_ARB_ISSUE`
  - `s_ARB_WAIT`
  - `s_ARB_CLEANUP`
- `s_ARB_IDLE`:
  - Stay while no `i_Req_DV` bit is high, or while `i_Tx_Active`=1.
  - Otherwise select the winner: the first requester with DV high, scanning upward (wrapping) from round-robin pointer `rr_ptr`.
  - On that edge, register the winner's byte into `o_Tx_Byte` and set `o_Grant` to the winner. Go to `s_ARB_ISSUE`.
- `s_ARB_ISSUE` (exactly 1 cycle):
  - `o_Tx_DV`=1.
  - `o_Req_Ack[winner]`=1.
  - Go to `s_ARB_WAIT`.
- `s_ARB_WAIT`:
  - Hold `o_Grant` and `o_Tx_Byte`.
  - On `i_Tx_Done`=1, go to `s_ARB_CLEANUP`.
- `s_ARB_CLEANUP` (exactly 1 cycle):
  - Clear `o_Grant`.
  - `rr_ptr` = (winner+1) mod `NUM_REQ`.
  - Go to `s_ARB_IDLE`.
- Fairness: a requester that has just been served gets the lowest priority at the next arbitration.
- `i_Tx_Done` is ignored in every state other than `s_ARB_WAIT`.
- Changes to `i_Req_DV` and `i_Req_Byte` are ignored outside `s_ARB_IDLE`.
- A requester that drops DV before being granted is simply not selected. No error is raised.
- Wrap-around: `rr_ptr`=`NUM_REQ`-1 plus a win advances `rr_ptr` to 0.

## Timing
- Reset values:
  - state = `s_ARB_IDLE`
  - `rr_ptr` = 0
  - `o_Req_Ack`, `o_Grant`, `o_Tx_DV`, `o_Tx_Byte`, `o_Busy`, `o_Timeout` all 0
- Reset asserted mid-transfer returns the block to `s_ARB_IDLE` immediately. No acknowledge is re-issued after reset.
- All outputs are registered.
- Request to `o_Tx_DV`: 1 cycle. DV sampled high at edge k; `o_Tx_DV` and `o_Req_Ack` are high in cycle k+1.
- Done to next grant:
  - `i_Tx_Done` at edge d, then CLEANUP in cycle d+1, then IDLE in cycle d+2.
  - The earliest next `o_Tx_DV` is in cycle d+3.
- A requester may deassert DV in the cycle after its `o_Req_Ack`.
- To send back-to-back bytes, the requester presents its next byte with DV held high after the ack.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in `s_ARB_WAIT` and is cleared on entry.
  - If it reaches `TIMEOUT_CYCLES`-1 with no `i_Tx_Done`, pulse `o_Timeout` for 1 cycle and go to `s_ARB_CLEANUP`. The pointer advances as normal.
- `UART_TX_ARB_TIMEOUT_EN` not defined:
  - No counter logic.
  - `o_Timeout` tied to 0.
  - `s_ARB_WAIT` waits indefinitely.

## Structure
- Package `uart_tx_arb_pkg` holds:
  - `arb_state_t`, the enum of the four states.
  - The default constants `ARB_NUM_REQ_DEF` and `ARB_TIMEOUT_DEF`.
- Sub-module `uart_tx_rr_picker` (combinational) computes the winner:
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot winner, winner index, any-request flag.
- Top level holds the FSM, registers and optional watchdog.

## Test plan
- Single request: req2 DV=1, byte 0xA5, `rr_ptr`=0.
  - Expect `o_Grant`=0100, with `o_Tx_DV` and `o_Req_Ack[2]` high in the same cycle, and `o_Tx_Byte`=0xA5.
  - After `i_Tx_Done`, expect `o_Grant`=0 and `rr_ptr`=3.
- All four requesters hold DV continuously with bytes 0x10..0x13.
  - Expect the UART to receive 0x10, 0x11, 0x12, 0x13, 0x10 in that order.
- `i_Tx_Active`=1 while req0 DV=1.
  - Expect no grant until `i_Tx_Active` falls; grant one cycle later.
- Reset asserted in `s_ARB_WAIT`.
  - Expect all outputs 0 and `rr_ptr`=0 immediately, with no ack afterwards.
- Stray `i_Tx_Done` in `s_ARB_IDLE`.
  - Expect no state change.
  - Then req1 is served normally.
- With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, `i_Tx_Done` never arrives.
  - Expect `o_Timeout` pulse 20 cycles after entering `s_ARB_WAIT`.
  - Then CLEANUP, and the next requester is granted.
